// File: rtl/isqrt_pipe.sv
// Fully pipelined unsigned integer square root, y = floor(sqrt(x)).
// One restoring-remainder stage per result bit; accepts one argument per cycle.
module isqrt_pipe #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 x_vld,
  input  logic [WIDTH-1:0]     x,
  output logic                 y_vld,
  output logic [WIDTH/2-1:0]   y,
  output logic                 idle
);

  localparam int N = WIDTH / 2;
  // Unconsumed argument bits shrink by two per stage, so they are packed
  // back-to-back: stage k owns WIDTH-2(k+1) bits starting at k*(2N-1-k).
  localparam int XR_BITS = N * (N - 1);

  logic [N-2:0]       vld_q;
  logic [N+1:0]       rem_q  [N-1];
  logic [N-1:0]       root_q [N-1];
  logic [XR_BITS-1:0] xr_q;

  genvar gi;
  generate
    for (gi = 0; gi < N - 1; gi++) begin : g_stage
      localparam int XW      = WIDTH - 2 * gi;
      localparam int OFF_OUT = gi * (2 * N - 1 - gi);

      logic          vld_in;
      logic [N+1:0]  rem_in;
      logic [N-1:0]  root_in;
      logic [XW-1:0] xr_in;

      logic [N+3:0]  r_full;
      logic [N+1:0]  t;
      logic          ge;

      logic          vld_reg;
      logic [N+1:0]  rem_reg;
      logic [N-1:0]  root_reg;
      logic [XW-3:0] xr_reg;

      if (gi == 0) begin : g_first
        assign vld_in  = x_vld;
        assign rem_in  = '0;
        assign root_in = '0;
        assign xr_in   = x;
      end else begin : g_next
        localparam int OFF_IN = (gi - 1) * (2 * N - gi);
        assign vld_in  = vld_q[gi-1];
        assign rem_in  = rem_q[gi-1];
        assign root_in = root_q[gi-1];
        assign xr_in   = xr_q[OFF_IN +: XW];
      end

      // Compare at full width so no remainder bit is silently dropped.
      assign r_full = {rem_in, xr_in[XW-1 -: 2]};
      assign t      = {root_in, 2'b01};
      assign ge     = (r_full >= {2'b00, t});

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_reg  <= 1'b0;
          rem_reg  <= '0;
          root_reg <= '0;
          xr_reg   <= '0;
        end else begin
          vld_reg <= vld_in;
          if (vld_in) begin
            rem_reg  <= ge ? (r_full[N+1:0] - t) : r_full[N+1:0];
            root_reg <= {root_in[N-2:0], ge};
            xr_reg   <= xr_in[XW-3:0];
          end
        end
      end

      assign vld_q[gi]                 = vld_reg;
      assign rem_q[gi]                 = rem_reg;
      assign root_q[gi]                = root_reg;
      assign xr_q[OFF_OUT +: (XW - 2)] = xr_reg;
    end
  endgenerate

  // Final stage only needs the root bit; its remainder is discarded.
  logic [N+3:0] r_last;
  logic [N+1:0] t_last;
  logic         ge_last;

  assign r_last  = {rem_q[N-2], xr_q[XR_BITS-1 -: 2]};
  assign t_last  = {root_q[N-2], 2'b01};
  assign ge_last = (r_last >= {2'b00, t_last});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_vld <= 1'b0;
      y     <= '0;
    end else begin
      y_vld <= vld_q[N-2];
      if (vld_q[N-2]) begin
        y <= {root_q[N-2][N-2:0], ge_last};
      end
    end
  end

  assign idle = ~(|vld_q | y_vld);

endmodule

// File: tb/tb_isqrt_pipe.sv
// Directed and random checks of isqrt_pipe at WIDTH=32, plus an exhaustive WIDTH=8 sweep.
module tb_isqrt_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        x_vld;
  logic [31:0] x;
  logic        y_vld;
  logic [15:0] y;
  logic        idle;

  logic        x8_vld;
  logic [7:0]  x8;
  logic        y8_vld;
  logic [3:0]  y8;
  logic        idle8;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit verbose = 1'b1;

  typedef struct {
    logic [15:0] exp;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t m32;
  exp_t m8;

  isqrt_pipe #(.WIDTH(32)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .x_vld (x_vld),
    .x     (x),
    .y_vld (y_vld),
    .y     (y),
    .idle  (idle)
  );

  isqrt_pipe #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .x_vld (x8_vld),
    .x     (x8),
    .y_vld (y8_vld),
    .y     (y8),
    .idle  (idle8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] isqrt_model(input logic [31:0] v);
    longint r;
    longint c;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      c = r | (longint'(1) << b);
      if (c * c <= longint'(v)) r = c;
    end
    return r[15:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n && y_vld) begin
      if (q32.size() == 0) begin
        check("u32_spurious_vld", 32'(y_vld), 32'd0);
      end else begin
        m32 = q32.pop_front();
        check("u32_y", 32'(y), 32'(m32.exp));
        check("u32_latency", 32'(cyc - m32.cyc), 32'd16);
        if (verbose) $display("[TB] u32 result y=0x%0h exp=0x%0h latency=%0d", y, m32.exp, cyc - m32.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && y8_vld) begin
      if (q8.size() == 0) begin
        check("u8_spurious_vld", 32'(y8_vld), 32'd0);
      end else begin
        m8 = q8.pop_front();
        check("u8_y", 32'(y8), 32'(m8.exp));
        check("u8_latency", 32'(cyc - m8.cyc), 32'd4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] val, input logic [15:0] e);
    x_vld = 1'b1;
    x     = val;
    q32.push_back('{exp: e, cyc: cyc});
    if (verbose) $display("[TB] u32 issue x=0x%0h", val);
    tick();
  endtask

  task automatic gap(input int n);
    x_vld = 1'b0;
    x     = 'x;
    repeat (n) tick();
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (q32.size() == 0 && q8.size() == 0) break;
      tick();
    end
    check("drain_timeout", 32'(q32.size() + q8.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued;
    int dens;
    logic [31:0] val;

    x_vld  = 1'b0;
    x      = '0;
    x8_vld = 1'b0;
    x8     = '0;
    rst_n  = 1'b0;
    repeat (3) tick();
    check("rst_y_vld", 32'(y_vld), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    rst_n = 1'b1;

    // First cycle after release.
    drive(32'd0, 16'd0);
    gap(5);
    check("idle_in_flight", 32'(idle), 32'd0);
    drain(40);
    tick();
    check("idle_after", 32'(idle), 32'd1);

    // Maximum-width remainder cases.
    drive(32'hFFFF_FFFF, 16'hFFFF);
    drive(32'hFFFE_0001, 16'hFFFF);
    drive(32'hFFFE_0000, 16'hFFFE);
    gap(1);
    drain(40);

    // Back-to-back, then y must hold.
    drive(32'd1,  16'd1);
    drive(32'd4,  16'd2);
    drive(32'd15, 16'd3);
    drive(32'd16, 16'd4);
    drive(32'd17, 16'd4);
    gap(1);
    drain(40);
    gap(3);
    check("hold_y", 32'(y), 32'd4);
    check("hold_y_vld", 32'(y_vld), 32'd0);

    // Gapped issue.
    drive(32'd9, 16'd3);
    gap(2);
    drive(32'd100, 16'd10);
    gap(1);
    drain(40);

    // Mid-flight reset drops everything in the pipe.
    drive(32'd1_000_000, 16'd1000);
    drive(32'd2, 16'd1);
    drive(32'd3, 16'd1);
    gap(2);
    rst_n = 1'b0;
    q32.delete();
    tick();
    tick();
    check("midrst_y", 32'(y), 32'd0);
    check("midrst_y_vld", 32'(y_vld), 32'd0);
    check("midrst_idle", 32'(idle), 32'd1);
    rst_n = 1'b1;
    gap(20);
    check("postrst_idle", 32'(idle), 32'd1);
    drive(32'd25, 16'd5);
    gap(1);
    drain(40);

    // Random arguments with varying issue density.
    verbose = 1'b0;
    issued  = 0;
    dens    = 50;
    while (issued < 10000) begin
      if ($urandom_range(0, 99) < dens) begin
        val = $urandom;
        drive(val, isqrt_model(val));
        issued++;
        if (issued % 1000 == 0) dens = $urandom_range(30, 100);
      end else begin
        gap(1);
      end
    end
    gap(1);
    drain(40);

    // Exhaustive WIDTH=8.
    for (int v = 0; v < 256; v++) begin
      x8_vld = 1'b1;
      x8     = 8'(v);
      q8.push_back('{exp: isqrt_model(32'(v)), cyc: cyc});
      tick();
    end
    x8_vld = 1'b0;
    x8     = 'x;
    drain(40);
    tick();
    check("u8_idle_after", 32'(idle8), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
